// File: rtl/data_mem_responder.sv
// data_mem_responder
// Data-memory slave for the DataPath MEM stage. It accepts one load/store over a
// valid/ready channel, waits LATENCY cycles and then returns a one-cycle
// response pulse. Storage is a word-organised big-endian RAM that supports
// byte, halfword and word accesses.
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              initiate,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int         DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [31:0]       mem [DEPTH];
  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              ready_q;
  logic              accept;

  logic              we_p0;
  logic              sgn_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [1:0]        size_p0;
  logic [31:0]       wdata_p0;
  logic              err_p0;
  logic [ADDR_W-3:0] word_idx;
  logic [31:0]       rd_word;

  // Pick the addressed lane (big-endian) and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bs;
    logic signed [31:0] hs;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h  = off[1] ? w[15:0] : w[31:16];
    bs = b;
    hs = h;
    case (size)
      2'b00:   load_extract = sgn ? bs : {24'b0, b};
      2'b01:   load_extract = sgn ? hs : {16'b0, h};
      default: load_extract = w;
    endcase
  endfunction

  // Replace only the addressed lanes of a word with right-justified store data.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    r[31:24] = d[7:0];
          2'd1:    r[23:16] = d[7:0];
          2'd2:    r[15:8]  = d[7:0];
          default: r[7:0]   = d[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[15:0] = d[15:0];
        else        r[31:16] = d[15:0];
      end
      2'b10:   r = d;
      default: r = w;
    endcase
    store_merge = r;
  endfunction

  assign req_ready = ready_q;
  assign accept    = req_valid & ready_q;
  assign word_idx  = addr_p0[ADDR_W-1:2];
  assign rd_word   = mem[word_idx];
  assign busy      = (state != IDLE) | rsp_valid;

  // Misaligned halfword/word and the reserved size code are errors.
  always_comb begin
    err_p0 = 1'b0;
    case (size_p0)
      2'b00:   err_p0 = 1'b0;
      2'b01:   err_p0 = addr_p0[0];
      2'b10:   err_p0 = (addr_p0[1:0] != 2'b00);
      default: err_p0 = 1'b1;
    endcase
  end

  // Request capture: all fields are held for the whole transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      sgn_p0   <= req_signed;
      addr_p0  <= req_addr;
      size_p0  <= req_size;
      wdata_p0 <= req_wdata;
    end
  end

  // Transaction FSM and response pulse; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!initiate) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ready_q   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= 4'd0;
            ready_q <= 1'b0;
            state   <= (LAT == 4'd0) ? RESP : WAIT;
          end else begin
            ready_q <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt + 4'd1 == LAT) state <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_p0;
          rsp_rdata <= (err_p0 | we_p0) ? 32'd0
                                        : load_extract(rd_word, addr_p0[1:0], size_p0, sgn_p0);
          state     <= IDLE;
          ready_q   <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Store commit happens on the response edge; errors and reset suppress it.
  always_ff @(posedge clk) begin
    if (initiate && state == RESP && we_p0 && !err_p0)
      mem[word_idx] <= store_merge(rd_word, addr_p0[1:0], size_p0, wdata_p0);
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios plus random traffic,
// checked by a queue-based scoreboard against a byte-array memory model.
module tb_data_mem_responder;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              initiate = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [31:0]       req_wdata = 32'd0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;

  data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk(clk), .initiate(initiate),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int last_acc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mb [1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory as a flat array of bytes; lowest address holds the most significant byte.
  function automatic exp_t model(input logic we, input logic [9:0] a, input logic [1:0] sz,
                                 input logic sg, input logic [31:0] wd);
    exp_t        e;
    int          n;
    logic [31:0] v;
    e.rdata = 32'd0;
    e.due   = 0;
    e.err   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    if (e.err) return e;
    n = 1 << sz;
    if (we) begin
      for (int i = 0; i < n; i++) mb[int'(a) + i] = wd[8*(n-1-i) +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | {24'd0, mb[int'(a) + i]};
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      e.rdata = v;
    end
    return e;
  endfunction

  // Present a request (valid stays high afterwards) and wait for it to be accepted.
  task automatic issue(input logic we, input logic [9:0] a, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd, input bit track);
    exp_t e;
    int   k;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_size   = sz;
    req_signed = sg;
    req_wdata  = wd;
    k = 0;
    while (req_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=req_ready %b required=1", req_ready);
      return;
    end
    if (track) begin
      e = model(we, a, sz, sg, wd);
      e.due = cyc + 2 + LAT;
      sbq.push_back(e);
    end
    last_acc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=rsp_valid 1 required=no response");
      end else begin
        e = sbq.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int prev;
    int k;
    // Reset state
    initiate = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    initiate = 1'b1;
    @(negedge clk);
    check("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // Known contents for the working region 0x000..0x03F
    for (int w = 0; w < 16; w++) issue(1'b1, 10'(w * 4), 2'b10, 1'b0, $urandom, 1'b1);
    idle(1);

    // Word store/load, then sub-word loads from the same word
    issue(1'b1, 10'h010, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 10'h010, 2'b10, 1'b0, 32'd0, 1'b1);
    idle(2);
    issue(1'b0, 10'h011, 2'b00, 1'b1, 32'd0, 1'b1);
    issue(1'b0, 10'h013, 2'b00, 1'b0, 32'd0, 1'b1);
    issue(1'b0, 10'h012, 2'b01, 1'b1, 32'd0, 1'b1);

    // Byte store preserves the other lanes
    issue(1'b1, 10'h012, 2'b00, 1'b0, 32'h00000055, 1'b1);
    issue(1'b0, 10'h010, 2'b10, 1'b0, 32'd0, 1'b1);

    // Misaligned accesses and illegal size report errors and write nothing
    issue(1'b1, 10'h012, 2'b10, 1'b0, 32'h11111111, 1'b1);
    issue(1'b0, 10'h013, 2'b01, 1'b1, 32'd0, 1'b1);
    issue(1'b1, 10'h010, 2'b11, 1'b0, 32'h22222222, 1'b1);
    issue(1'b0, 10'h010, 2'b10, 1'b0, 32'd0, 1'b1);

    // Continuous req_valid with alternating store/load: one accept per LAT+2 cycles
    for (int i = 0; i < 8; i++) begin
      prev = last_acc;
      if (i % 2 == 0) issue(1'b1, 10'h030, 2'b10, 1'b0, 32'hA5A50000 + 32'(i), 1'b1);
      else            issue(1'b0, 10'h030, 2'b10, 1'b0, 32'd0, 1'b1);
      if (i > 0) check("b2b_spacing", 32'(last_acc - prev), 32'(LAT + 2));
    end
    idle(2);

    // Store aborted by reset while waiting: no response, no write
    issue(1'b1, 10'h020, 2'b10, 1'b0, 32'h12345678, 1'b0);
    @(negedge clk);
    check("wait_busy", {31'd0, busy}, 32'd1);
    check("wait_req_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    initiate  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    initiate = 1'b1;
    idle(4);
    issue(1'b0, 10'h020, 2'b10, 1'b0, 32'd0, 1'b1);
    idle(2);

    // Random traffic within the initialised region
    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom, 1'b1);
      idle($urandom_range(0, 2));
    end

    idle(1);
    k = 0;
    while (sbq.size() > 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
